// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle for unified_mem_arbiter: CPU fetch port, CPU load/store port
// and the single memory port. The slave modport is the arbiter's view; the
// master modport is the view of whatever drives the CPU and memory sides.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_valid;

    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;
    logic              d_valid;

    logic              m_req;
    logic              m_we;
    logic [3:0]        m_be;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic              m_gnt;
    logic [31:0]       m_rdata;
    logic              m_rvalid;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_valid,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_rdata, d_valid,
        output m_req, m_we, m_be, m_addr, m_wdata,
        input  m_gnt, m_rdata, m_rvalid
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_valid,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_rdata, d_valid,
        input  m_req, m_we, m_be, m_addr, m_wdata,
        output m_gnt, m_rdata, m_rvalid
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between instruction
// fetch and load/store. Data wins ties; a starvation counter forces a fetch
// after STARVE_LIMIT consecutive data grants with a fetch pending.
// Optional feature: define MEMARB_IFBUF_EN for a one-entry fetch buffer.
//
// state | meaning
// IDLE  | sample requests, pick winner, latch its fields
// ISSUE | m_req high until m_gnt
// WAIT  | waiting for m_rvalid, capture read data
// RESP  | one-cycle *_valid to the owner
module unified_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    unified_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_own_d;
    logic              r_m_we;
    logic [3:0]        r_m_be;
    logic [ADDR_W-1:0] r_m_addr;
    logic [31:0]       r_m_wdata;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_d_rdata;
    logic [3:0]        r_starve_cnt;

    logic              w_starved;
    logic              w_pick_d;
    logic              w_pick_if;
    logic              w_hit;
    logic              w_unused;

    assign w_unused = &{1'b0, bus.if_addr[1:0], bus.d_addr[1:0]};

`ifdef MEMARB_IFBUF_EN
    logic              r_buf_vld;
    logic [ADDR_W-3:0] r_buf_tag;
    logic [31:0]       r_buf_data;
`endif

    // Winner selection: data first unless the fetch has waited long enough.
    always_comb begin
        w_starved = (r_starve_cnt == LP_LIMIT);
        w_pick_d  = bus.d_req && !(bus.if_req && w_starved);
        w_pick_if = bus.if_req && !w_pick_d;
    end

    // Fetch buffer hit; without the buffer every fetch goes to memory.
    always_comb begin
`ifdef MEMARB_IFBUF_EN
        w_hit = w_pick_if && r_buf_vld &&
                (r_buf_tag == bus.if_addr[ADDR_W-1:2]);
`else
        w_hit = 1'b0;
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_hit)                      w_state_nxt = ST_RESP;
                      else if (w_pick_d || w_pick_if) w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (bus.m_gnt)                  w_state_nxt = ST_WAIT;
            ST_WAIT:  if (bus.m_rvalid)               w_state_nxt = ST_RESP;
            ST_RESP:                                  w_state_nxt = ST_IDLE;
            default:                                  w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch the winner's request fields in IDLE and the read data in WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_own_d    <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_be     <= 4'h0;
            r_m_addr   <= '0;
            r_m_wdata  <= 32'h0;
            r_if_rdata <= 32'h0;
            r_d_rdata  <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_d) begin
                        r_own_d   <= 1'b1;
                        r_m_addr  <= {bus.d_addr[ADDR_W-1:2], 2'b00};
                        r_m_we    <= bus.d_we;
                        r_m_be    <= bus.d_we ? bus.d_be : 4'hF;
                        r_m_wdata <= bus.d_we ? bus.d_wdata : 32'h0;
                    end else if (w_pick_if) begin
                        r_own_d   <= 1'b0;
                        r_m_addr  <= {bus.if_addr[ADDR_W-1:2], 2'b00};
                        r_m_we    <= 1'b0;
                        r_m_be    <= 4'hF;
                        r_m_wdata <= 32'h0;
`ifdef MEMARB_IFBUF_EN
                        if (w_hit) r_if_rdata <= r_buf_data;
`endif
                    end
                end
                ST_WAIT: begin
                    if (bus.m_rvalid) begin
                        if (!r_own_d)     r_if_rdata <= bus.m_rdata;
                        else if (!r_m_we) r_d_rdata  <= bus.m_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Count data grants made while a fetch waits; any fetch grant clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= 4'h0;
        end else if (r_state == ST_IDLE) begin
            if (w_pick_if || !bus.if_req)
                r_starve_cnt <= 4'h0;
            else if (w_pick_d && (r_starve_cnt != LP_LIMIT))
                r_starve_cnt <= r_starve_cnt + 4'h1;
        end
    end

`ifdef MEMARB_IFBUF_EN
    // Fill on every completed fetch; a store to the buffered word kills it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf_vld  <= 1'b0;
            r_buf_tag  <= '0;
            r_buf_data <= 32'h0;
        end else if ((r_state == ST_WAIT) && bus.m_rvalid && !r_own_d) begin
            r_buf_vld  <= 1'b1;
            r_buf_tag  <= r_m_addr[ADDR_W-1:2];
            r_buf_data <= bus.m_rdata;
        end else if ((r_state == ST_IDLE) && w_pick_d && bus.d_we &&
                     (r_buf_tag == bus.d_addr[ADDR_W-1:2])) begin
            r_buf_vld  <= 1'b0;
        end
    end
`endif

    assign bus.m_req    = (r_state == ST_ISSUE);
    assign bus.m_we     = r_m_we;
    assign bus.m_be     = r_m_be;
    assign bus.m_addr   = r_m_addr;
    assign bus.m_wdata  = r_m_wdata;
    assign bus.if_rdata = r_if_rdata;
    assign bus.d_rdata  = r_d_rdata;
    assign bus.if_valid = (r_state == ST_RESP) && !r_own_d;
    assign bus.d_valid  = (r_state == ST_RESP) && r_own_d;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Testbench for unified_mem_arbiter: CPU-side requesters and a memory model
// share one negedge process; expected responses are queued when a request
// is presented and compared when the matching *_valid arrives.
module tb_unified_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    unified_mem_arbiter_if #(.ADDR_W(32)) bus ();

    unified_mem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata; int lat; } req_t;
    typedef struct { logic [31:0] data; int cyc0; int lat; } exp_t;
    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; int cnt; } gnt_t;

    req_t        if_todo[$];
    req_t        d_todo[$];
    exp_t        if_exp[$];
    exp_t        d_exp[$];
    gnt_t        gnt_log[$];
    gnt_t        stall_log[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] last_d_exp = 32'h0;
    logic [31:0] pend_rdata = 32'h0;
    int          rv_cnt     = 0;
    int          rv_delay   = 1;
    int          gnt_stall  = 0;
    int          n_valid    = 0;
    int          n_rv       = 0;
    int          n_cmp      = 0;
    int          n_err      = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (32'hC0DE_0000 ^ a);
    endfunction

    task automatic mem_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] v;
        v = mem_rd(a);
        for (int b = 0; b < 4; b++)
            if (be[b]) v[b*8 +: 8] = wd[b*8 +: 8];
        mem[a] = v;
    endtask

    // CPU requesters, scoreboard pops and memory responder, all at negedge.
    initial begin
        req_t r;
        exp_t e;
        gnt_t g;
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0;
        bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        bus.m_gnt = 1'b1; bus.m_rvalid = 1'b0; bus.m_rdata = 32'hBAD0BAD0;
        forever begin
            @(negedge clk);
            bus.m_rvalid = 1'b0;
            bus.m_rdata  = 32'hBAD0BAD0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    bus.m_rvalid = 1'b1;
                    bus.m_rdata  = pend_rdata;
                    n_rv++;
                end
            end
            if (reset) begin
                bus.if_req = 1'b0;
                bus.d_req  = 1'b0;
                if_todo.delete(); d_todo.delete();
                if_exp.delete();  d_exp.delete();
            end else begin
                if (bus.if_valid) begin
                    n_valid++;
                    if (if_exp.size() == 0) check_val("if_spurious", 1, 0);
                    else begin
                        e = if_exp.pop_front();
                        check_val("if_rdata", bus.if_rdata, e.data);
                        if (e.lat >= 0) check_val("if_lat", cyc - e.cyc0, e.lat);
                    end
                    bus.if_req = 1'b0;
                end
                if (bus.d_valid) begin
                    n_valid++;
                    if (d_exp.size() == 0) check_val("d_spurious", 1, 0);
                    else begin
                        e = d_exp.pop_front();
                        check_val("d_rdata", bus.d_rdata, e.data);
                        if (e.lat >= 0) check_val("d_lat", cyc - e.cyc0, e.lat);
                    end
                    bus.d_req = 1'b0;
                end
                if (!bus.if_req && if_todo.size() > 0) begin
                    r = if_todo.pop_front();
                    bus.if_req  = 1'b1;
                    bus.if_addr = r.addr;
                    e.data = mem_rd(r.addr & ~32'h3);
                    e.cyc0 = cyc;
                    e.lat  = r.lat;
                    if_exp.push_back(e);
                end
                if (!bus.d_req && d_todo.size() > 0) begin
                    r = d_todo.pop_front();
                    bus.d_req   = 1'b1;
                    bus.d_we    = r.we;
                    bus.d_be    = r.be;
                    bus.d_addr  = r.addr;
                    bus.d_wdata = r.wdata;
                    if (r.we) e.data = last_d_exp;
                    else begin
                        e.data = mem_rd(r.addr & ~32'h3);
                        last_d_exp = e.data;
                    end
                    e.cyc0 = cyc;
                    e.lat  = r.lat;
                    d_exp.push_back(e);
                end
            end
            g.addr = bus.m_addr; g.we = bus.m_we; g.be = bus.m_be;
            g.wdata = bus.m_wdata; g.cnt = int'(dut.r_starve_cnt);
            if (bus.m_req) begin
                if (gnt_stall > 0) begin
                    bus.m_gnt = 1'b0;
                    gnt_stall--;
                    stall_log.push_back(g);
                end else begin
                    bus.m_gnt = 1'b1;
                    gnt_log.push_back(g);
                    check_val("m_addr_align", bus.m_addr[1:0], 0);
                    pend_rdata = mem_rd(bus.m_addr);
                    if (bus.m_we) mem_wr(bus.m_addr, bus.m_be, bus.m_wdata);
                    rv_cnt = rv_delay;
                end
            end else begin
                bus.m_gnt = 1'b1;
            end
        end
    end

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (if_todo.size() == 0 && d_todo.size() == 0 && if_exp.size() == 0 &&
                d_exp.size() == 0 && !bus.if_req && !bus.d_req && rv_cnt == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check_val(tag, ok, 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic push_if(input logic [31:0] a, input int lat);
        if_todo.push_back('{1'b0, 4'hF, a, 32'h0, lat});
    endtask

    task automatic push_d(input logic we, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] wd, input int lat);
        d_todo.push_back('{we, be, a, wd, lat});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int rv0;
        logic seen;
        reset = 1'b1;
        mem[32'h0]  = 32'h00100093;
        mem[32'h4]  = 32'h11223344;
        mem[32'h10] = 32'h00200113;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_m_req",    bus.m_req, 0);
        check_val("rst_m_we",     bus.m_we, 0);
        check_val("rst_m_be",     bus.m_be, 0);
        check_val("rst_m_addr",   bus.m_addr, 0);
        check_val("rst_m_wdata",  bus.m_wdata, 0);
        check_val("rst_if_out",   {bus.if_valid, bus.if_rdata}, 0);
        check_val("rst_d_out",    {bus.d_valid, bus.d_rdata}, 0);
        check_val("rst_state",    int'(dut.r_state), 0);
        check_val("rst_starve",   int'(dut.r_starve_cnt), 0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk);

        // Fetch only, unaligned address.
        gnt_log.delete();
        push_if(32'h2, 3);
        wait_idle("fetch_done");
        check_val("fetch_ngnt", gnt_log.size(), 1);
        if (gnt_log.size() > 0) begin
            check_val("fetch_addr", gnt_log[0].addr, 32'h0);
            check_val("fetch_be",   gnt_log[0].be, 4'hF);
            check_val("fetch_we",   gnt_log[0].we, 0);
        end
        check_val("fetch_word", bus.if_rdata, 32'h00100093);

        // Contention: data first, fetch 4 cycles after d_valid.
        gnt_log.delete();
        push_if(32'h10, 7);
        push_d(1'b0, 4'h0, 32'h4, 32'h0, 3);
        wait_idle("cont_done");
        check_val("cont_ngnt", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            check_val("cont_first",  gnt_log[0].addr, 32'h4);
            check_val("cont_second", gnt_log[1].addr, 32'h10);
        end
        check_val("cont_dword", bus.d_rdata, 32'h11223344);

        // Starvation: four data grants, then the fetch, then data resumes.
        begin
            logic [31:0] exp_a [7];
            int          exp_c [7];
            exp_a = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h100, 32'h210, 32'h214};
            exp_c = '{1, 2, 3, 4, 0, 0, 0};
            gnt_log.delete();
            push_if(32'h100, -1);
            for (int i = 0; i < 6; i++) push_d(1'b0, 4'h0, 32'h200 + 4 * i, 32'h0, -1);
            wait_idle("starve_done");
            check_val("starve_ngnt", gnt_log.size(), 7);
            if (gnt_log.size() == 7)
                for (int i = 0; i < 7; i++) begin
                    check_val($sformatf("starve_addr%0d", i), gnt_log[i].addr, exp_a[i]);
                    check_val($sformatf("starve_cnt%0d", i), gnt_log[i].cnt, exp_c[i]);
                end
        end

        // Store with partial byte enables, then read it back.
        gnt_log.delete();
        push_d(1'b1, 4'b0011, 32'h6, 32'hDEADBEEF, 3);
        wait_idle("store_done");
        check_val("store_ngnt", gnt_log.size(), 1);
        if (gnt_log.size() > 0) begin
            check_val("store_addr",  gnt_log[0].addr, 32'h4);
            check_val("store_be",    gnt_log[0].be, 4'b0011);
            check_val("store_we",    gnt_log[0].we, 1);
            check_val("store_wdata", gnt_log[0].wdata, 32'hDEADBEEF);
        end
        push_d(1'b0, 4'h0, 32'h4, 32'h0, 3);
        wait_idle("reload_done");
        check_val("reload_word", bus.d_rdata, 32'h1122BEEF);

        // Grant stall of 3 cycles.
        stall_log.delete();
        gnt_stall = 3;
        push_d(1'b0, 4'h0, 32'h8, 32'h0, 6);
        wait_idle("stall_done");
        check_val("stall_n", stall_log.size(), 3);
        foreach (stall_log[i]) begin
            check_val("stall_addr", stall_log[i].addr, 32'h8);
            check_val("stall_be",   stall_log[i].be, 4'hF);
            check_val("stall_we",   stall_log[i].we, 0);
        end

        // Reset in WAIT, late m_rvalid afterwards.
        gnt_log.delete();
        rv_delay = 4;
        push_d(1'b0, 4'h0, 32'hC, 32'h0, -1);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (gnt_log.size() > 0) begin
                seen = 1'b1;
                break;
            end
        end
        check_val("rst_mid_gnt", seen, 1);
        #1 reset = 1'b1;
        v0  = n_valid;
        rv0 = n_rv;
        @(posedge clk); #1 reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rv_delay = 1;
        check_val("rst_mid_late_rv", n_rv - rv0, 1);
        check_val("rst_mid_novalid", n_valid - v0, 0);
        check_val("rst_mid_state",   int'(dut.r_state), 0);
        check_val("rst_mid_mbus",    {bus.m_req, bus.m_we, bus.m_be, bus.m_addr, 23'h0}, 0);
        check_val("rst_mid_wdata",   bus.m_wdata, 0);
        check_val("rst_mid_rdata",   {bus.if_rdata, bus.d_rdata}, 0);
        last_d_exp = 32'h0;

`ifdef MEMARB_IFBUF_EN
        // Fetch buffer: repeat hit skips memory, store to the word invalidates.
        gnt_log.delete();
        push_if(32'h20, 3);
        wait_idle("buf_fill");
        check_val("buf_fill_ngnt", gnt_log.size(), 1);
        gnt_log.delete();
        push_if(32'h20, 1);
        wait_idle("buf_hit");
        check_val("buf_hit_ngnt", gnt_log.size(), 0);
        push_d(1'b1, 4'hF, 32'h20, 32'h0BADF00D, 3);
        wait_idle("buf_store");
        gnt_log.delete();
        push_if(32'h20, 3);
        wait_idle("buf_miss");
        check_val("buf_miss_ngnt", gnt_log.size(), 1);
        check_val("buf_miss_word", bus.if_rdata, 32'h0BADF00D);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
